mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- N-channel arbiter that multiplexes cache-line requesters (I-cache, D-cache, future prefetch/victim buffers) onto one physical memory port.
- Generalises the two-port instruction/data arbitration to a parameterised channel count.
- Adds round-robin or fixed-priority selection, a registered grant, and an explicit post-response turnaround so channels are serviced fairly without re-grant hazards.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 is the I-cache by convention.
- LINE_W, 256, line data width in bits.
- ADDR_W, 32, address width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, lowest channel index wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ch_read  in  NUM_CH  per-channel line read request; held until ch_resp.
- ch_write  in  NUM_CH  per-channel line write request; held until ch_resp.
- ch_address  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  packed write lines; channel i occupies bits [i*LINE_W +: LINE_W].
- ch_resp  out  NUM_CH  one-hot completion pulse to the granted channel.
- ch_rdata  out  LINE_W  pmem_rdata broadcast to all channels; qualified by ch_resp.
- pmem_resp  in  1  memory completion.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_read  out  1  memory read request.
- pmem_write  out  1  memory write request.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write line.
- grant_id  out  $clog2(NUM_CH) (min 1)  index of the current or last granted channel; debug/perf.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - pmem_read, pmem_write, ch_resp, busy = 0.
  - pmem_address and pmem_wdata = 0.
  - Reset mid-transaction abandons the outstanding pmem request. A pmem_resp arriving after reset release while in IDLE is ignored.
- Request of channel i: req[i] = ch_read[i] | ch_write[i].
- FSM states: IDLE, BUSY, TURN.
- IDLE:
  - If any req bit is set, select a winner and register grant_id = winner; next state BUSY. Otherwise stay in IDLE.
  - Winner selection, round-robin: first set req bit scanning from rr_ptr upward, wrapping NUM_CH-1 to 0.
  - Winner selection, FIXED_PRIO=1: lowest set index.
- BUSY:
  - pmem_read = ch_read[grant_id] & ~ch_write[grant_id].
  - pmem_write = ch_write[grant_id]. A channel asserting both read and write is treated as a write.
  - pmem_address and pmem_wdata are driven combinationally from the granted channel's slices.
  - On pmem_resp: ch_resp[grant_id]=1 in the same cycle (combinational); rr_ptr <= (grant_id+1) mod NUM_CH; next state TURN.
  - Without pmem_resp, stay in BUSY, with no timeout.
- TURN:
  - Lasts exactly one cycle. pmem_read, pmem_write and ch_resp are all 0. Requests are not sampled.
  - Next state IDLE. This lets the serviced cache drop its request before re-arbitration.
- Latency:
  - Request asserted in IDLE at cycle t produces pmem_read/pmem_write at t+1.
  - Minimum per-transaction occupancy is 3 cycles (IDLE, BUSY with immediate resp, TURN).
  - Back-to-back grants are therefore spaced by at least one idle bus cycle.
- Outputs outside BUSY: pmem_read=pmem_write=0. pmem_address and pmem_wdata hold the granted channel's slices and are don't-care to memory.
- A channel dropping its request while in BUSY is a protocol violation. The arbiter keeps the grant; the pmem strobes follow the live channel inputs.
- ch_rdata = pmem_rdata at all times.
- busy = (state==BUSY). grant_id is held through TURN and IDLE until the next grant.
- rr_ptr updates only on completion, never on grant. Channels not requesting do not advance the pointer.

Test Plan:
- NUM_CH=2, only ch_read[1]=1, ch_address[1]=0x0000_1040, pmem_resp 3 cycles later with rdata=0xA5..A5 -> pmem_read high at t+1 with address 0x0000_1040; ch_resp=2'b10 in the resp cycle; ch_rdata=0xA5..A5; TURN then IDLE; rr_ptr=0.
- Round-robin: ch0 and ch1 both read continuously, pmem_resp after 1 cycle -> grants alternate 0,1,0,1; each grant spaced 3 cycles; ch_resp one-hot each time.
- FIXED_PRIO=1, NUM_CH=2, both requesting continuously -> every grant goes to ch0; ch1 is granted only after ch0 drops its request.
- Write path: ch_write[0]=1 with ch_read[0]=1, wdata=0xDEAD..BEEF, address 0x2000 -> pmem_write=1, pmem_read=0, pmem_wdata=0xDEAD..BEEF, pmem_address=0x2000.
- NUM_CH=4 wrap: channels 1 and 3 requesting, rr_ptr=2 -> grant 3, then on the next arbitration grant 1 (pointer wrapped 3 to 0, ch0 idle so ch1 wins).
- Reset mid-BUSY: rst_n low while pmem_read=1 -> pmem_read=0 asynchronously; after release state=IDLE, rr_ptr=0; a stray pmem_resp in IDLE produces no ch_resp.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//
// Multiplexes NUM_CH cache-line requesters (channel 0 = I-cache, then D-cache,
// prefetch, victim buffers, ...) onto a single physical memory port.
// Arbitration is round-robin (FIXED_PRIO=0) or fixed priority with the lowest
// index winning (FIXED_PRIO=1). The grant is registered, and every transaction
// ends with a one-cycle TURN state so the serviced channel can drop its request
// before the next arbitration.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   ch_read        per-channel read request, held until ch_resp
//   ch_write       per-channel write request, held until ch_resp (wins over read)
//   ch_address     packed addresses, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata       packed write lines, channel i at [i*LINE_W +: LINE_W]
//   ch_resp        one-hot completion pulse to the granted channel
//   ch_rdata       pmem_rdata broadcast, qualified by ch_resp
//   pmem_resp      memory completion
//   pmem_rdata     memory read line
//   pmem_read      memory read strobe (BUSY only)
//   pmem_write     memory write strobe (BUSY only)
//   pmem_address   granted channel's address
//   pmem_wdata     granted channel's write line
//   grant_id       current / last granted channel
//   busy           high while a transaction is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
  parameter int NUM_CH     = 2,
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0,
  localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [LINE_W-1:0]        ch_rdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [GW-1:0]   rr_ptr, rr_ptr_d;
  logic [GW-1:0]   grant_d;
  logic            granted_q, granted_d;

  logic [NUM_CH-1:0] req;
  logic              any_req;
  logic [GW-1:0]     winner;
  logic              found;
  int                cand;

  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic [NUM_CH-1:0] grant_onehot;

  // ---------------------------------------------------------------------------
  // Winner selection. Candidates are visited in priority order: from rr_ptr
  // upward with wrap for round-robin, from index 0 for fixed priority. The
  // inner loop keeps every bit-select constant.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // before any branch; a path that leaves one unassigned infers a latch.
    req     = ch_read | ch_write;
    any_req = |req;
    winner  = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (FIXED_PRIO != 0) begin
        cand = k;
      end else begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_CH) cand = cand - NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && (i == cand) && req[i]) begin
          winner = GW'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted channel's slices. The strobes follow the live channel inputs, so a
  // channel that misbehaves by dropping its request mid-BUSY simply drops the
  // strobe while keeping the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_read     = 1'b0;
    sel_write    = 1'b0;
    sel_addr     = '0;
    sel_wdata    = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_id == GW'(i)) begin
        sel_read        = ch_read[i];
        sel_write       = ch_write[i];
        sel_addr        = ch_address[i*ADDR_W +: ADDR_W];
        sel_wdata       = ch_wdata[i*LINE_W +: LINE_W];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    grant_d   = grant_id;
    rr_ptr_d  = rr_ptr;
    granted_d = granted_q;
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_d   = winner;
          granted_d = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // The pointer moves on completion only, to the channel after the one
        // just serviced.
        if (pmem_resp) begin
          rr_ptr_d = (grant_id == GW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
          state_d  = S_TURN;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      granted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_id  <= grant_d;
      granted_q <= granted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state == S_BUSY);
  assign pmem_read  = busy & sel_read & ~sel_write;
  assign pmem_write = busy & sel_write;
  assign ch_resp    = (busy && pmem_resp) ? grant_onehot : '0;
  assign ch_rdata   = pmem_rdata;

  // NOTE: the address/data mux is held at zero until the first grant after
  // reset, so the bus shows zeros in reset instead of channel 0's live inputs.
  assign pmem_address = granted_q ? sel_addr  : '0;
  assign pmem_wdata   = granted_q ? sel_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter_rr
//
// Three instances share clk/rst_n/pmem_rdata:
//   d0: NUM_CH=2 round-robin, d1: NUM_CH=2 fixed priority, d2: NUM_CH=4
//   round-robin. Expected transactions are queued when requests are driven and
//   popped when the addressed instance raises a pmem strobe.
// -----------------------------------------------------------------------------
module tb_mem_arbiter_rr;

  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [LW-1:0] pmem_rdata;
  logic [2:0]    presp;

  // d0
  logic [1:0]      rd0, wr0, p0_resp;
  logic [2*AW-1:0] addr0;
  logic [2*LW-1:0] wd0;
  logic [LW-1:0]   p0_rdata, p0_wdata;
  logic            p0_read, p0_write, p0_busy;
  logic [AW-1:0]   p0_addr;
  logic [0:0]      p0_grant;
  // d1
  logic [1:0]      rd1, wr1, p1_resp;
  logic [2*AW-1:0] addr1;
  logic [2*LW-1:0] wd1;
  logic [LW-1:0]   p1_rdata, p1_wdata;
  logic            p1_read, p1_write, p1_busy;
  logic [AW-1:0]   p1_addr;
  logic [0:0]      p1_grant;
  // d2
  logic [3:0]      rd2, wr2, p2_resp;
  logic [4*AW-1:0] addr2;
  logic [4*LW-1:0] wd2;
  logic [LW-1:0]   p2_rdata, p2_wdata;
  logic            p2_read, p2_write, p2_busy;
  logic [AW-1:0]   p2_addr;
  logic [1:0]      p2_grant;

  mem_arbiter_rr #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .FIXED_PRIO(0)) d0 (
    .clk(clk), .rst_n(rst_n), .ch_read(rd0), .ch_write(wr0),
    .ch_address(addr0), .ch_wdata(wd0), .ch_resp(p0_resp), .ch_rdata(p0_rdata),
    .pmem_resp(presp[0]), .pmem_rdata(pmem_rdata), .pmem_read(p0_read),
    .pmem_write(p0_write), .pmem_address(p0_addr), .pmem_wdata(p0_wdata),
    .grant_id(p0_grant), .busy(p0_busy));

  mem_arbiter_rr #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .FIXED_PRIO(1)) d1 (
    .clk(clk), .rst_n(rst_n), .ch_read(rd1), .ch_write(wr1),
    .ch_address(addr1), .ch_wdata(wd1), .ch_resp(p1_resp), .ch_rdata(p1_rdata),
    .pmem_resp(presp[1]), .pmem_rdata(pmem_rdata), .pmem_read(p1_read),
    .pmem_write(p1_write), .pmem_address(p1_addr), .pmem_wdata(p1_wdata),
    .grant_id(p1_grant), .busy(p1_busy));

  mem_arbiter_rr #(.NUM_CH(4), .LINE_W(LW), .ADDR_W(AW), .FIXED_PRIO(0)) d2 (
    .clk(clk), .rst_n(rst_n), .ch_read(rd2), .ch_write(wr2),
    .ch_address(addr2), .ch_wdata(wd2), .ch_resp(p2_resp), .ch_rdata(p2_rdata),
    .pmem_resp(presp[2]), .pmem_rdata(pmem_rdata), .pmem_read(p2_read),
    .pmem_write(p2_write), .pmem_address(p2_addr), .pmem_wdata(p2_wdata),
    .grant_id(p2_grant), .busy(p2_busy));

  // Uniform views of the three instances, indexed by instance number.
  logic [2:0]    m_read, m_write, m_busy;
  logic [7:0]    m_resp  [3];
  logic [2:0]    m_grant [3];
  logic [AW-1:0] m_addr  [3];
  logic [LW-1:0] m_wdata [3];
  logic [LW-1:0] m_rdata [3];

  assign m_read     = {p2_read,  p1_read,  p0_read};
  assign m_write    = {p2_write, p1_write, p0_write};
  assign m_busy     = {p2_busy,  p1_busy,  p0_busy};
  assign m_resp[0]  = {6'b0, p0_resp};
  assign m_resp[1]  = {6'b0, p1_resp};
  assign m_resp[2]  = {4'b0, p2_resp};
  assign m_grant[0] = {2'b0, p0_grant};
  assign m_grant[1] = {2'b0, p1_grant};
  assign m_grant[2] = {1'b0, p2_grant};
  assign m_addr[0]  = p0_addr;
  assign m_addr[1]  = p1_addr;
  assign m_addr[2]  = p2_addr;
  assign m_wdata[0] = p0_wdata;
  assign m_wdata[1] = p1_wdata;
  assign m_wdata[2] = p2_wdata;
  assign m_rdata[0] = p0_rdata;
  assign m_rdata[1] = p1_rdata;
  assign m_rdata[2] = p2_rdata;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [AW-1:0] addr, input logic wr,
                      input logic [LW-1:0] wdata);
    exp_t e;
    e.ch = ch; e.addr = addr; e.wr = wr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Waits (bounded) for instance d to raise a strobe, compares it with the
  // head of the scoreboard, answers after `delay` extra BUSY cycles and checks
  // the completion and the TURN cycle. Returns in the TURN cycle; `waited` is
  // the number of edges between the call and the strobe.
  task automatic serve(input int d, input int delay, output int waited);
    exp_t          e;
    logic          seen;
    logic [LW-1:0] rdata;
    logic [LW-1:0] one;
    waited = 0;
    seen   = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (m_read[d] || m_write[d]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      waited++;
    end
    check("strobe_seen", seen, 1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    check("grant_id", m_grant[d], e.ch);
    check("pmem_address", m_addr[d], e.addr);
    check("pmem_write", m_write[d], e.wr);
    check("pmem_read", m_read[d], !e.wr);
    if (e.wr) check("pmem_wdata", m_wdata[d], e.wdata);
    check("busy", m_busy[d], 1);
    check("resp_early", m_resp[d], 0);
    repeat (delay) begin
      @(posedge clk); #1;
      check("busy_hold", m_busy[d], 1);
      check("resp_hold", m_resp[d], 0);
    end
    for (int w = 0; w < LW / 32; w++) rdata[w*32 +: 32] = $urandom;
    pmem_rdata = rdata;
    presp[d]   = 1'b1;
    #1;
    one = 1;
    check("ch_resp", m_resp[d], one << e.ch);
    check("ch_rdata", m_rdata[d], rdata);
    @(posedge clk); #1;
    presp[d] = 1'b0;
    #1;
    check("turn_busy", m_busy[d], 0);
    check("turn_strobe", m_read[d] | m_write[d], 0);
    check("turn_resp", m_resp[d], 0);
    check("turn_grant", m_grant[d], e.ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            w;
    logic [LW-1:0] deadbeef;
    logic [LW-1:0] wd_ch3;
    deadbeef = {8{32'hDEAD_BEEF}};
    wd_ch3   = {8{32'h3C3C_5A5A}};

    // ---------------- Reset ----------------
    rst_n = 1'b0;
    presp = '0;
    pmem_rdata = '0;
    rd0 = '0; wr0 = '0; wd0 = '0;
    rd1 = '0; wr1 = '0; wd1 = '0;
    rd2 = '0; wr2 = '0; wd2 = '0;
    addr0 = {32'h0000_1040, 32'h0000_2000};
    addr1 = {32'h0000_3100, 32'h0000_3000};
    addr2 = {32'h0000_40C0, 32'h0000_4080, 32'h0000_4040, 32'h0000_4000};
    wd0[0 +: LW]    = deadbeef;
    wd2[3*LW +: LW] = wd_ch3;
    #3;
    for (int d = 0; d < 3; d++) begin
      check("rst_read", m_read[d], 0);
      check("rst_write", m_write[d], 0);
      check("rst_resp", m_resp[d], 0);
      check("rst_busy", m_busy[d], 0);
      check("rst_grant", m_grant[d], 0);
      check("rst_addr", m_addr[d], 0);
      check("rst_wdata", m_wdata[d], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- Single read on ch1, 3-cycle memory latency ----------------
    rd0 = 2'b10;
    push(1, 32'h0000_1040, 1'b0, '0);
    serve(0, 3, w);
    check("latency_t1", w, 1);
    rd0 = 2'b00;
    @(posedge clk); #1;
    check("idle_busy", m_busy[0], 0);
    check("idle_strobe", m_read[0] | m_write[0], 0);
    check("idle_grant_held", m_grant[0], 1);

    // ---------------- Round-robin alternation (pointer back at 0) ----------------
    rd0 = 2'b11;
    for (int i = 0; i < 4; i++)
      push(i % 2, (i % 2) ? 32'h0000_1040 : 32'h0000_2000, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      serve(0, 0, w);
      if (i == 0) check("rr_first_latency", w, 1);
      else        check("rr_spacing", w + 1, 3);
    end
    rd0 = 2'b00;
    @(posedge clk); #1;

    // ---------------- Write path: read+write on ch0 is a write ----------------
    rd0 = 2'b01;
    wr0 = 2'b01;
    push(0, 32'h0000_2000, 1'b1, deadbeef);
    serve(0, 1, w);
    rd0 = 2'b00;
    wr0 = 2'b00;
    @(posedge clk); #1;

    // ---------------- Reset mid-BUSY (pointer is 1 here) ----------------
    rd0 = 2'b10;
    @(posedge clk); #1;
    check("pre_rst_read", m_read[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_read", m_read[0], 0);
    check("async_rst_busy", m_busy[0], 0);
    check("async_rst_grant", m_grant[0], 0);
    rd0 = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    presp[0] = 1'b1;
    #1;
    check("stray_resp", m_resp[0], 0);
    @(posedge clk); #1;
    presp[0] = 1'b0;
    check("stray_busy", m_busy[0], 0);
    check("stray_strobe", m_read[0] | m_write[0], 0);
    // Pointer must be back at 0: ch0 wins over ch1.
    rd0 = 2'b11;
    push(0, 32'h0000_2000, 1'b0, '0);
    serve(0, 0, w);
    rd0 = 2'b00;
    @(posedge clk); #1;

    // ---------------- Fixed priority ----------------
    rd1 = 2'b11;
    for (int i = 0; i < 3; i++) push(0, 32'h0000_3000, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      serve(1, 0, w);
      if (i > 0) check("fp_spacing", w + 1, 3);
    end
    rd1 = 2'b10;
    push(1, 32'h0000_3100, 1'b0, '0);
    serve(1, 0, w);
    rd1 = 2'b00;
    @(posedge clk); #1;

    // ---------------- NUM_CH=4 wrap ----------------
    rd2 = 4'b0010;
    push(1, 32'h0000_4040, 1'b0, '0);
    serve(2, 0, w);
    rd2 = 4'b0000;
    @(posedge clk); #1;
    // Pointer is now 2; channels 1 and 3 (write) request.
    rd2 = 4'b0010;
    wr2 = 4'b1000;
    push(3, 32'h0000_40C0, 1'b1, wd_ch3);
    push(1, 32'h0000_4040, 1'b0, '0);
    push(3, 32'h0000_40C0, 1'b1, wd_ch3);
    for (int i = 0; i < 3; i++) serve(2, i, w);
    rd2 = 4'b0000;
    wr2 = 4'b0000;
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
